// File: rtl/key_debounce.sv
// key_debounce: per-key debounce with press/release pulses and auto-repeat, driven by a 1 ms tick.
module key_debounce #(
  parameter int F_CLK           = 50000000,
  parameter int N_KEY           = 6,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_KEY-1:0] key,
  output logic [N_KEY-1:0] key_state,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic [N_KEY-1:0] key_repeat
);
  localparam int DIV  = F_CLK / 1000;
  localparam int TW   = DIV > 1 ? $clog2(DIV) : 1;
  localparam int DW   = DEBOUNCE_MS > 1 ? $clog2(DEBOUNCE_MS) : 1;
  localparam int RMAX = REPEAT_DELAY_MS > REPEAT_RATE_MS ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW   = RMAX > 1 ? $clog2(RMAX) : 1;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [N_KEY-1:0] sync1_q, key_sync_q;
  logic [N_KEY-1:0] key_state_q, key_state_d, key_press_q, key_press_d;
  logic [N_KEY-1:0] key_release_q, key_release_d, key_repeat_q, key_repeat_d;
  logic [DW-1:0]    db_cnt_q [N_KEY];
  logic [DW-1:0]    db_cnt_d [N_KEY];
  logic [RW-1:0]    rpt_cnt_q [N_KEY];
  logic [RW-1:0]    rpt_cnt_d [N_KEY];
  state_t           st_q [N_KEY];
  state_t           st_d [N_KEY];
  assign key_state   = key_state_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_repeat  = key_repeat_q;
  always_comb begin
    tick       = tick_cnt_q == TW'(DIV - 1);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    for (int i = 0; i < N_KEY; i++) begin
      key_state_d[i]   = key_state_q[i];
      key_press_d[i]   = 1'b0;
      key_release_d[i] = 1'b0;
      key_repeat_d[i]  = 1'b0;
      db_cnt_d[i]      = db_cnt_q[i];
      rpt_cnt_d[i]     = rpt_cnt_q[i];
      st_d[i]          = st_q[i];
      if (key_sync_q[i] == key_state_q[i])
        db_cnt_d[i] = '0;
      else if (tick) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_MS - 1)) begin
          key_state_d[i]   = key_sync_q[i];
          key_press_d[i]   = key_sync_q[i];
          key_release_d[i] = ~key_sync_q[i];
          db_cnt_d[i]      = '0;
        end else
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
      // an accepted release overrides any repeat expiry on the same edge
      if (key_press_d[i] || key_release_d[i]) begin
        st_d[i]      = key_press_d[i] ? DELAY : IDLE;
        rpt_cnt_d[i] = '0;
      end else if (tick && st_q[i] != IDLE) begin
        if (rpt_cnt_q[i] == (st_q[i] == DELAY ? RW'(REPEAT_DELAY_MS - 1) : RW'(REPEAT_RATE_MS - 1))) begin
          key_repeat_d[i] = 1'b1;
          rpt_cnt_d[i]    = '0;
          st_d[i]         = REPEAT;
        end else
          rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q    <= '0;
      sync1_q       <= '0;
      key_sync_q    <= '0;
      key_state_q   <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      key_repeat_q  <= '0;
      for (int i = 0; i < N_KEY; i++) begin
        db_cnt_q[i]  <= '0;
        rpt_cnt_q[i] <= '0;
        st_q[i]      <= IDLE;
      end
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      sync1_q       <= key;
      key_sync_q    <= sync1_q;
      key_state_q   <= key_state_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      key_repeat_q  <= key_repeat_d;
      for (int i = 0; i < N_KEY; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
        st_q[i]      <= st_d[i];
      end
    end
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scenario tasks with hand-computed pulse timing (1 tick per cycle).
module tb_key_debounce;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] key = '0;
  logic [5:0] key_state, key_press, key_release, key_repeat;
  int errors = 0;
  int checks = 0;
  key_debounce #(
    .F_CLK(1000), .N_KEY(6), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(3)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .key_repeat(key_repeat)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    #2;
    checks++;
    if ({key_state, key_press, key_release, key_repeat} !== 24'h0) begin
      errors++;
      $display("FAIL reset outputs got %h exp 0", {key_state, key_press, key_release, key_repeat});
    end
    step(2);
    rst = 1'b0;
    step(3);
    checks++;
    if ({key_state, key_press, key_release, key_repeat} !== 24'h0) begin
      errors++;
      $display("FAIL idle outputs got %h exp 0", {key_state, key_press, key_release, key_repeat});
    end
  endtask
  task automatic test_clean_press;
    key[0] = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step(1);
      checks++;
      if (key_press !== (j == 6 ? 6'b000001 : 6'b0) || key_state !== (j >= 6 ? 6'b000001 : 6'b0) || key_repeat !== 6'b0) begin
        errors++;
        $display("FAIL clean_press j=%0d press=%b state=%b rep=%b", j, key_press, key_state, key_repeat);
      end
    end
    key[0] = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      step(1);
      checks++;
      if (key_release !== (j == 6 ? 6'b000001 : 6'b0) || key_state !== (j >= 6 ? 6'b0 : 6'b000001) || key_repeat !== 6'b0) begin
        errors++;
        $display("FAIL clean_release j=%0d rel=%b state=%b rep=%b", j, key_release, key_state, key_repeat);
      end
    end
  endtask
  task automatic test_glitch;
    logic [23:0] seen;
    seen = '0;
    key[1] = 1'b1;
    step(3);
    key[1] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      seen |= {key_state, key_press, key_release, key_repeat};
      step(1);
    end
    checks++;
    if (seen !== 24'h0) begin
      errors++;
      $display("FAIL glitch3 outputs got %h exp 0", seen);
    end
    key[1] = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      step(1);
      if (j == 4) key[1] = 1'b0;
      if (j == 6 || j == 10) begin
        checks++;
        if (key_press !== (j == 6 ? 6'b000010 : 6'b0) || key_release !== (j == 10 ? 6'b000010 : 6'b0)) begin
          errors++;
          $display("FAIL glitch4 j=%0d press=%b rel=%b", j, key_press, key_release);
        end
      end
    end
  endtask
  task automatic test_auto_repeat;
    key[2] = 1'b1;
    step(6);
    checks++;
    if (key_press !== 6'b000100) begin
      errors++;
      $display("FAIL repeat_press got %b exp 000100", key_press);
    end
    for (int j = 1; j <= 30; j++) begin
      step(1);
      checks++;
      if (key_repeat !== ((j == 10 || j == 13 || j == 16 || j == 19 || j == 22) ? 6'b000100 : 6'b0) ||
          key_release !== (j == 25 ? 6'b000100 : 6'b0) || (key_repeat & key_press) !== 6'b0) begin
        errors++;
        $display("FAIL auto_repeat j=%0d rep=%b rel=%b", j, key_repeat, key_release);
      end
      if (j == 19) key[2] = 1'b0;
    end
  endtask
  task automatic test_release_race;
    key[3] = 1'b1;
    step(6);
    checks++;
    if (key_press !== 6'b001000) begin
      errors++;
      $display("FAIL race_press got %b exp 001000", key_press);
    end
    for (int j = 1; j <= 20; j++) begin
      step(1);
      if (j == 4) key[3] = 1'b0;
      checks++;
      if (key_repeat !== 6'b0 || key_release !== (j == 10 ? 6'b001000 : 6'b0)) begin
        errors++;
        $display("FAIL release_race j=%0d rep=%b rel=%b", j, key_repeat, key_release);
      end
    end
  endtask
  task automatic test_simultaneous;
    key = 6'b100001;
    step(6);
    checks++;
    if (key_press !== 6'b100001 || key_state !== 6'b100001) begin
      errors++;
      $display("FAIL simul_press got %b state %b exp 100001", key_press, key_state);
    end
    key = 6'b0;
    step(6);
    checks++;
    if (key_release !== 6'b100001 || key_state !== 6'b0) begin
      errors++;
      $display("FAIL simul_release got %b state %b exp 100001", key_release, key_state);
    end
    step(2);
  endtask
  task automatic test_reset_mid_hold;
    key[4] = 1'b1;
    step(6);
    checks++;
    if (key_press !== 6'b010000) begin
      errors++;
      $display("FAIL mid_press got %b exp 010000", key_press);
    end
    step(12);
    rst = 1'b1;
    #1;
    checks++;
    if ({key_state, key_press, key_release, key_repeat} !== 24'h0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0", {key_state, key_press, key_release, key_repeat});
    end
    step(2);
    rst = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      step(1);
      checks++;
      if (key_press !== (j == 6 ? 6'b010000 : 6'b0) || key_repeat !== 6'b0 || key_release !== 6'b0) begin
        errors++;
        $display("FAIL post_reset j=%0d press=%b rep=%b rel=%b", j, key_press, key_repeat, key_release);
      end
    end
    key[4] = 1'b0;
    step(8);
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_auto_repeat();
    test_release_race();
    test_simultaneous();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter F_CLK, default 50000000: clock frequency in Hz; F_CLK/1000 SHALL be >= 1.
REQ-002 Parameter N_KEY, default 6: number of independent key channels.
REQ-003 Parameter DEBOUNCE_MS, default 20: stable time in ms required to accept a level change; >= 1.
REQ-004 Parameter REPEAT_DELAY_MS, default 500: hold time in ms from key_press to the first key_repeat; >= 1.
REQ-005 Parameter REPEAT_RATE_MS, default 100: period in ms between later key_repeat pulses; >= 1.
REQ-006 clk  in  1  system clock; one clock domain; all state SHALL update on its rising edge.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 key  in  N_KEY  raw push-button levels; 1 = pressed; asynchronous to clk; may bounce.
REQ-009 key_state  out  N_KEY  debounced level per key; registered.
REQ-010 key_press  out  N_KEY  one-cycle pulse on each accepted 0->1 transition.
REQ-011 key_release  out  N_KEY  one-cycle pulse on each accepted 1->0 transition.
REQ-012 key_repeat  out  N_KEY  one-cycle auto-repeat pulse while a key stays held.

Function
REQ-013 Tick: a free-running counter SHALL run from 0 to F_CLK/1000-1 and wrap; tick is high for exactly one cycle when the count equals F_CLK/1000-1. For F_CLK=1000, tick is high every cycle.
REQ-014 Each key bit SHALL pass through a 2-flop synchronizer; key_sync[i] is the second flop output.
REQ-015 Per key, db_cnt: if key_sync[i]==key_state[i], db_cnt SHALL clear to 0 on that edge, with or without a tick.
REQ-016 Otherwise, on a tick: if db_cnt==DEBOUNCE_MS-1, key_state[i] SHALL take key_sync[i] and db_cnt SHALL clear; else db_cnt SHALL increment. With no tick, db_cnt SHALL hold.
REQ-017 key_press[i] SHALL be high for one cycle, registered at the same edge where key_state[i] becomes 1; key_release[i] likewise at the edge where it becomes 0.
REQ-018 Counter widths SHALL hold the maximum count without wrap.
REQ-019 Per key repeat FSM, states IDLE, DELAY, REPEAT, with counter rpt_cnt:
  - IDLE -> DELAY with rpt_cnt=0 at the edge where key_press[i] is set;
  - DELAY, on a tick: if rpt_cnt==REPEAT_DELAY_MS-1, pulse key_repeat, rpt_cnt=0, go to REPEAT; else rpt_cnt+1;
  - REPEAT, on a tick: if rpt_cnt==REPEAT_RATE_MS-1, pulse key_repeat, rpt_cnt=0; else rpt_cnt+1;
  - counting SHALL start on the edge after entering DELAY.
REQ-020 An accepted 1->0 transition in DELAY or REPEAT SHALL force IDLE with rpt_cnt=0 on that edge; no key_repeat pulse on that edge (release wins over a same-cycle expiry).
REQ-021 key_repeat[i] and key_press[i] SHALL never be high in the same cycle.
REQ-022 Channels SHALL be fully independent; simultaneous presses and releases on several keys SHALL each produce their own pulses in the same cycle.
REQ-023 A glitch shorter than DEBOUNCE_MS consecutive ticks of disagreement SHALL produce no change on any output.

Reset
REQ-024 While rst=1: key_state, key_press, key_release, key_repeat, synchronizer flops, tick counter, db_cnt and rpt_cnt SHALL all be 0, and every FSM SHALL be IDLE, without needing a clock edge.
REQ-025 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse.
REQ-026 A key held through reset release SHALL be accepted as a new press after the normal debounce delay.

Verification (F_CLK=1000, DEBOUNCE_MS=4, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=3)
REQ-027 Clean press: key[0] rises before edge k and stays high -> key_state[0]=1 and key_press[0] pulses at edge k+5, one cycle wide; other bits stay 0.
REQ-028 Glitch: key[1] high for exactly 3 cycles -> no output change. Key[1] high for 4 cycles -> key_press[1] then key_release[1] pulses.
REQ-029 Auto-repeat: key[2] held, key_press[2] at edge p -> key_repeat[2] pulses at p+10, p+13, p+16, ... until release; no pulse on or after the release edge.
REQ-030 Release race: key_state[3] falls at the edge where the DELAY count would expire -> key_release[3] pulses, no key_repeat[3], FSM returns to IDLE.
REQ-031 Simultaneous: key[0] and key[5] rise together -> both key_press bits pulse at the same edge.
REQ-032 Reset mid-hold: rst asserted during REPEAT -> all outputs 0 immediately. With key still high after rst falls -> key_press again 5 edges after the first post-reset edge.
